// File: rtl/seven_segment_mux_counter.sv
// Prescaled DIGITS-wide BCD/hex up/down counter on a time-multiplexed seven-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).
module seven_segment_mux_counter #(
  parameter int CLK_FREQ    = 50000000,
  parameter int TICK_HZ     = 1,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_ena,
  input  logic       io_down,
  input  logic       io_hexMode,
  input  logic       io_clear,
  output logic [7:0] io_sevenSeg,
  output logic [7:0] io_digitSel,
  output logic       io_tick,
  output logic       io_wrap
);

  localparam int PRESC_TERM = CLK_FREQ / TICK_HZ - 1;
  localparam int PW = (PRESC_TERM > 0) ? $clog2(PRESC_TERM + 1) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int CW = 4 * DIGITS;
  localparam logic [PW-1:0] PRESC_LAST   = PW'(PRESC_TERM);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [2:0]    INDEX_LAST   = 3'(DIGITS - 1);

  logic [PW-1:0] presc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_d;
  logic [CW-1:0] stepped;
  logic          roll;
  logic          carry;
  logic [3:0]    digit;
  logic [3:0]    max_digit;
  logic          hex_r;
  logic          tick_now;
  logic          mode_change;
  logic [RW-1:0] ref_cnt;
  logic          refresh_wrap;
  logic [2:0]    index;
  logic [2:0]    index_d;
  logic [3:0]    cur_digit;
  logic [6:0]    glyph;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign tick_now     = io_ena && (presc == PRESC_LAST);
  assign mode_change  = io_hexMode != hex_r;
  assign refresh_wrap = ref_cnt == REFRESH_LAST;

  // Ripple a +/-1 through the digits; a carry out of the top digit is a rollover.
  always_comb begin
    max_digit = hex_r ? 4'hF : 4'd9;
    stepped   = count;
    carry     = 1'b1;
    digit     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = count[4*i +: 4];
      if (carry) begin
        if (io_down) begin
          if (digit == 4'd0) begin
            stepped[4*i +: 4] = max_digit;
          end else begin
            stepped[4*i +: 4] = digit - 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == max_digit) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = digit + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    roll = carry;
  end

  always_comb begin
    count_d = count;
    if (io_clear || mode_change) begin
      count_d = '0;
    end else if (tick_now) begin
      count_d = stepped;
    end
  end

  always_comb begin
    index_d = index;
    if (refresh_wrap) begin
      index_d = (index == INDEX_LAST) ? 3'd0 : index + 3'd1;
    end
  end

  // Decode from next-state count and index so digit select and segments move together.
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (3'(i) == index_d) begin
        cur_digit = count_d[4*i +: 4];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic blank;
  logic zeros_up;

  always_comb begin
    zeros_up = 1'b1;
    blank    = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zeros_up = zeros_up && (count_d[4*i +: 4] == 4'd0);
      if (3'(i) == index_d) begin
        blank = zeros_up;
      end
    end
  end

  assign glyph = blank ? 7'h00 : seg_decode(cur_digit);
`else
  assign glyph = seg_decode(cur_digit);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      presc       <= '0;
      count       <= '0;
      hex_r       <= 1'b0;
      ref_cnt     <= '0;
      index       <= 3'd0;
      io_tick     <= 1'b0;
      io_wrap     <= 1'b0;
      io_digitSel <= 8'h01;
      io_sevenSeg <= 8'h3F;
    end else begin
      hex_r   <= io_hexMode;
      io_tick <= tick_now;
      io_wrap <= tick_now && roll && !io_clear && !mode_change;
      if (io_clear || tick_now) begin
        presc <= '0;
      end else if (io_ena) begin
        presc <= presc + 1'b1;
      end
      count       <= count_d;
      ref_cnt     <= refresh_wrap ? '0 : ref_cnt + 1'b1;
      index       <= index_d;
      io_digitSel <= 8'h01 << index_d;
      io_sevenSeg <= {(index_d == 3'd0) && io_ena, glyph};
    end
  end

endmodule
